// File: rtl/uop_decode_queue.sv
// RV32I/M front-end decoder feeding a decoded-uop FIFO with valid/ready on both sides,
// flush and sticky halt. Optional macro DECODE_MULDIV_EN enables the MUL class.
module uop_decode_queue #(
    parameter int XLEN    = 32,
    parameter int Q_DEPTH = 8,
    parameter int CNT_W   = $clog2(Q_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [31:0]      instr_in,
    input  logic             valid_instr_in,
    output logic             instr_ready_out,
    input  logic             flush_in,
    output logic             uop_valid_out,
    input  logic             uop_ready_in,
    output logic [6:0]       uop_out,
    output logic             eoi_out,
    output logic [XLEN-1:0]  imm_out,
    output logic             use_imm_out,
    output logic [XLEN-1:0]  pc_out,
    output logic             except_out,
    output logic [4:0]       src1_arch_out,
    output logic [4:0]       src2_arch_out,
    output logic [4:0]       dest_arch_out,
    output logic [CNT_W-1:0] count_out,
    output logic             halted_out
);
    localparam int PTR_W = $clog2(Q_DEPTH);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] CLS_LSU  = 3'b001;
    localparam logic [2:0] CLS_ALU  = 3'b010;
    localparam logic [2:0] CLS_BR   = 3'b011;
`ifdef DECODE_MULDIV_EN
    localparam logic [2:0] CLS_MUL  = 3'b100;
`endif

    typedef struct packed {
        logic [6:0]      uop;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic [XLEN-1:0] pc;
        logic            except;
        logic [4:0]      src1;
        logic [4:0]      src2;
        logic [4:0]      dest;
    } entry_t;

    entry_t           r_mem [Q_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_halted;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    entry_t          w_dec;
    logic            w_illegal;
    logic            w_dec_halt;
    logic            w_push;
    logic            w_pop;
    logic            w_out_en;
    entry_t          w_head;

    assign w_opcode = instr_in[6:0];
    assign w_f3     = instr_in[14:12];
    assign w_f7     = instr_in[31:25];
    assign w_rd     = instr_in[11:7];
    assign w_rs1    = instr_in[19:15];
    assign w_rs2    = instr_in[24:20];

    assign w_imm_i = XLEN'($signed(instr_in[31:20]));
    assign w_imm_s = XLEN'($signed({instr_in[31:25], instr_in[11:7]}));
    assign w_imm_b = XLEN'($signed({instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({instr_in[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0}));

    // Unused register fields stay zero so rename never sees false dependencies.
    always_comb begin
        w_dec      = '0;
        w_dec.pc   = pc_in;
        w_illegal  = 1'b0;
        w_dec_halt = 1'b0;
        if (instr_in == 32'hDEADBEEF) begin
            w_dec.uop  = 7'h7F;
            w_dec_halt = 1'b1;
        end else begin
            case (w_opcode)
                OPC_OP: begin
                    w_dec.src1 = w_rs1;
                    w_dec.src2 = w_rs2;
                    w_dec.dest = w_rd;
                    if (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) begin
                        w_dec.uop = {CLS_ALU, w_f7[5], w_f3};
`ifdef DECODE_MULDIV_EN
                    end else if (w_f7 == 7'b0000001) begin
                        w_dec.uop = {CLS_MUL, 1'b0, w_f3};
`endif
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                OPC_OP_IMM: begin
                    w_dec.uop     = {CLS_ALU, (w_f3 == 3'b101) & instr_in[30], w_f3};
                    w_dec.imm     = w_imm_i;
                    w_dec.use_imm = 1'b1;
                    w_dec.src1    = w_rs1;
                    w_dec.dest    = w_rd;
                end
                OPC_LOAD: begin
                    w_dec.uop     = {CLS_LSU, 1'b0, w_f3};
                    w_dec.imm     = w_imm_i;
                    w_dec.use_imm = 1'b1;
                    w_dec.src1    = w_rs1;
                    w_dec.dest    = w_rd;
                end
                OPC_STORE: begin
                    w_dec.uop  = {CLS_LSU, 1'b1, w_f3};
                    w_dec.imm  = w_imm_s;
                    w_dec.src1 = w_rs1;
                    w_dec.src2 = w_rs2;
                end
                OPC_BRANCH: begin
                    w_dec.uop  = {CLS_BR, 1'b0, w_f3};
                    w_dec.imm  = w_imm_b;
                    w_dec.src1 = w_rs1;
                    w_dec.src2 = w_rs2;
                end
                OPC_JAL: begin
                    w_dec.uop     = {CLS_BR, 4'b1000};
                    w_dec.imm     = w_imm_j;
                    w_dec.use_imm = 1'b1;
                    w_dec.dest    = w_rd;
                end
                OPC_JALR: begin
                    w_dec.uop     = {CLS_BR, 4'b1001};
                    w_dec.imm     = w_imm_i;
                    w_dec.use_imm = 1'b1;
                    w_dec.src1    = w_rs1;
                    w_dec.dest    = w_rd;
                end
                OPC_LUI: begin
                    w_dec.uop     = {CLS_ALU, 4'b0000};
                    w_dec.imm     = w_imm_u;
                    w_dec.use_imm = 1'b1;
                    w_dec.dest    = w_rd;
                end
                OPC_AUIPC: begin
                    w_dec.uop     = {CLS_ALU, 4'b1111};
                    w_dec.imm     = w_imm_u;
                    w_dec.use_imm = 1'b1;
                    w_dec.dest    = w_rd;
                end
                default: w_illegal = 1'b1;
            endcase
        end
        if (w_illegal) begin
            w_dec        = '0;
            w_dec.pc     = pc_in;
            w_dec.except = 1'b1;
        end
    end

    // Ready never depends on pop: a full queue refuses input even while draining.
    assign instr_ready_out = !rst && (r_count < CNT_W'(Q_DEPTH)) && !r_halted && !flush_in;
    assign w_push          = valid_instr_in && instr_ready_out;
    assign w_pop           = (r_count != '0) && uop_ready_in && !flush_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else if (flush_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
            if (w_push && w_dec_halt) r_halted <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_dec;
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign w_out_en = !rst && (r_count != '0);

    assign uop_valid_out = w_out_en;
    assign uop_out       = w_out_en ? w_head.uop     : '0;
    assign eoi_out       = w_out_en;
    assign imm_out       = w_out_en ? w_head.imm     : '0;
    assign use_imm_out   = w_out_en ? w_head.use_imm : 1'b0;
    assign pc_out        = w_out_en ? w_head.pc      : '0;
    assign except_out    = w_out_en ? w_head.except  : 1'b0;
    assign src1_arch_out = w_out_en ? w_head.src1    : '0;
    assign src2_arch_out = w_out_en ? w_head.src2    : '0;
    assign dest_arch_out = w_out_en ? w_head.dest    : '0;
    assign count_out     = rst ? '0 : r_count;
    assign halted_out    = r_halted && !rst;

endmodule

// File: tb/tb_uop_decode_queue.sv
// Directed bench for uop_decode_queue (Q_DEPTH = 4): decode vector table plus
// backpressure, wrap, halt, flush and reset sequences.
module tb_uop_decode_queue;
    localparam int XLEN  = 32;
    localparam int QD    = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [XLEN-1:0]  pc_in;
    logic [31:0]      instr_in;
    logic             valid_instr_in;
    logic             instr_ready_out;
    logic             flush_in;
    logic             uop_valid_out;
    logic             uop_ready_in;
    logic [6:0]       uop_out;
    logic             eoi_out;
    logic [XLEN-1:0]  imm_out;
    logic             use_imm_out;
    logic [XLEN-1:0]  pc_out;
    logic             except_out;
    logic [4:0]       src1_arch_out;
    logic [4:0]       src2_arch_out;
    logic [4:0]       dest_arch_out;
    logic [CNT_W-1:0] count_out;
    logic             halted_out;

    uop_decode_queue #(.XLEN(XLEN), .Q_DEPTH(QD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
        .valid_instr_in(valid_instr_in), .instr_ready_out(instr_ready_out),
        .flush_in(flush_in), .uop_valid_out(uop_valid_out), .uop_ready_in(uop_ready_in),
        .uop_out(uop_out), .eoi_out(eoi_out), .imm_out(imm_out), .use_imm_out(use_imm_out),
        .pc_out(pc_out), .except_out(except_out), .src1_arch_out(src1_arch_out),
        .src2_arch_out(src2_arch_out), .dest_arch_out(dest_arch_out),
        .count_out(count_out), .halted_out(halted_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [6:0]  uop;
        logic [31:0] imm;
        logic        use_imm;
        logic        exc;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [4:0]  d;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [4:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic push_one(input logic [31:0] ins, input logic [31:0] pc);
        instr_in       = ins;
        pc_in          = pc;
        valid_instr_in = 1'b1;
        step();
        valid_instr_in = 1'b0;
        #1;
    endtask

    task automatic pop_one();
        uop_ready_in = 1'b1;
        step();
        uop_ready_in = 1'b0;
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'h100, 7'h20, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd0, 5'd0, 5'd1};
        vecs[1]  = '{32'h002081B3, 32'h104, 7'h20, 32'h0,        1'b0, 1'b0, 5'd1, 5'd2, 5'd3};
        vecs[2]  = '{32'h402081B3, 32'h108, 7'h28, 32'h0,        1'b0, 1'b0, 5'd1, 5'd2, 5'd3};
`ifdef DECODE_MULDIV_EN
        vecs[3]  = '{32'h022081B3, 32'h10C, 7'h40, 32'h0,        1'b0, 1'b0, 5'd1, 5'd2, 5'd3};
`else
        vecs[3]  = '{32'h022081B3, 32'h10C, 7'h00, 32'h0,        1'b0, 1'b1, 5'd0, 5'd0, 5'd0};
`endif
        vecs[4]  = '{32'h0000007F, 32'h110, 7'h00, 32'h0,        1'b0, 1'b1, 5'd0, 5'd0, 5'd0};
        vecs[5]  = '{32'hFE000EE3, 32'h114, 7'h30, 32'hFFFFFFFC, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0};
        vecs[6]  = '{32'h12345237, 32'h118, 7'h20, 32'h12345000, 1'b1, 1'b0, 5'd0, 5'd0, 5'd4};
        vecs[7]  = '{32'hFFFFF297, 32'h11C, 7'h2F, 32'hFFFFF000, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5};
        vecs[8]  = '{32'hFE20AC23, 32'h120, 7'h1A, 32'hFFFFFFF8, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0};
        vecs[9]  = '{32'h0100A183, 32'h124, 7'h12, 32'h00000010, 1'b1, 1'b0, 5'd1, 5'd0, 5'd3};
        vecs[10] = '{32'h4033D313, 32'h128, 7'h2D, 32'h00000403, 1'b1, 1'b0, 5'd7, 5'd0, 5'd6};
        vecs[11] = '{32'h008000EF, 32'h12C, 7'h38, 32'h00000008, 1'b1, 1'b0, 5'd0, 5'd0, 5'd1};
        vecs[12] = '{32'h00008067, 32'h130, 7'h39, 32'h0,        1'b1, 1'b0, 5'd1, 5'd0, 5'd0};
        vecs[13] = '{32'h202081B3, 32'h134, 7'h00, 32'h0,        1'b0, 1'b1, 5'd0, 5'd0, 5'd0};

        rst = 1'b1; pc_in = '0; instr_in = 32'h00000013; valid_instr_in = 1'b1;
        flush_in = 1'b0; uop_ready_in = 1'b0;
        step();
        step();
        chk("rst_ready", instr_ready_out, 0);
        chk("rst_valid", uop_valid_out, 0);
        chk("rst_count", count_out, 0);
        chk("rst_halted", halted_out, 0);
        chk("rst_eoi", eoi_out, 0);
        valid_instr_in = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", instr_ready_out, 1);

        // Decode table: one instruction through an empty queue at a time.
        for (int i = 0; i < NV; i++) begin
            push_one(vecs[i].instr, vecs[i].pc);
            chk($sformatf("v%0d_valid", i), uop_valid_out, 1);
            chk($sformatf("v%0d_uop", i), uop_out, vecs[i].uop);
            chk($sformatf("v%0d_imm", i), imm_out, vecs[i].imm);
            chk($sformatf("v%0d_use_imm", i), use_imm_out, vecs[i].use_imm);
            chk($sformatf("v%0d_except", i), except_out, vecs[i].exc);
            chk($sformatf("v%0d_src1", i), src1_arch_out, vecs[i].s1);
            chk($sformatf("v%0d_src2", i), src2_arch_out, vecs[i].s2);
            chk($sformatf("v%0d_dest", i), dest_arch_out, vecs[i].d);
            chk($sformatf("v%0d_pc", i), pc_out, vecs[i].pc);
            chk($sformatf("v%0d_eoi", i), eoi_out, 1);
            pop_one();
            chk($sformatf("v%0d_drained", i), count_out, 0);
        end

        // Fill to depth with backpressure, then pop, push+pop across the wrap, drain.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            instr_in       = 32'hFFF00013 | (32'(i + 1) << 7);
            pc_in          = 32'h200 + 32'(4 * i);
            valid_instr_in = 1'b1;
            #1;
            chk($sformatf("fill%0d_ready", i), instr_ready_out, (i < QD) ? 1 : 0);
            if (instr_ready_out) exp_q.push_back(5'(i + 1));
            step();
        end
        valid_instr_in = 1'b0;
        #1;
        chk("full_count", count_out, 4);
        chk("full_ready", instr_ready_out, 0);
        uop_ready_in = 1'b1;
        #1;
        chk("pop1_dest", dest_arch_out, exp_q.pop_front());
        step();
        uop_ready_in = 1'b0;
        #1;
        chk("pop1_count", count_out, 3);
        chk("pop1_ready", instr_ready_out, 1);
        instr_in       = 32'hFFF00313;
        valid_instr_in = 1'b1;
        uop_ready_in   = 1'b1;
        #1;
        chk("pushpop_dest", dest_arch_out, exp_q.pop_front());
        exp_q.push_back(5'd6);
        step();
        valid_instr_in = 1'b0;
        uop_ready_in   = 1'b0;
        #1;
        chk("pushpop_count", count_out, 3);
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
            uop_ready_in = 1'b1;
            #1;
            chk($sformatf("drain%0d_valid", k), uop_valid_out, 1);
            chk($sformatf("drain%0d_dest", k), dest_arch_out, exp_q.pop_front());
            step();
        end
        uop_ready_in = 1'b0;
        #1;
        chk("drain_count", count_out, 0);
        chk("drain_valid", uop_valid_out, 0);

        // Sticky halt: the ADD behind the halt word must never enter.
        do_reset();
        push_one(32'hFFF00093, 32'h300);
        instr_in       = 32'hDEADBEEF;
        pc_in          = 32'h304;
        valid_instr_in = 1'b1;
        step();
        instr_in = 32'h002081B3;
        pc_in    = 32'h308;
        #1;
        chk("halt_flag", halted_out, 1);
        chk("halt_ready", instr_ready_out, 0);
        repeat (3) step();
        chk("halt_count", count_out, 2);
        valid_instr_in = 1'b0;
        chk("halt_head0_dest", dest_arch_out, 1);
        pop_one();
        chk("halt_uop", uop_out, 7'h7F);
        chk("halt_eoi", eoi_out, 1);
        chk("halt_pc", pc_out, 32'h304);
        chk("halt_except", except_out, 0);
        chk("halt_regs", {src1_arch_out, src2_arch_out, dest_arch_out}, 0);
        pop_one();
        chk("halt_drained", count_out, 0);
        chk("halt_still", halted_out, 1);
        chk("halt_still_ready", instr_ready_out, 0);
        do_reset();
        chk("halt_cleared", halted_out, 0);
        chk("halt_cleared_ready", instr_ready_out, 1);

        // Flush with a valid input and pending pop in the same cycle.
        push_one(32'hFFF00093, 32'h400);
        push_one(32'hFFF00113, 32'h404);
        push_one(32'hFFF00193, 32'h408);
        chk("flush_pre_count", count_out, 3);
        flush_in       = 1'b1;
        instr_in       = 32'h002081B3;
        valid_instr_in = 1'b1;
        uop_ready_in   = 1'b1;
        #1;
        chk("flush_ready", instr_ready_out, 0);
        step();
        flush_in       = 1'b0;
        valid_instr_in = 1'b0;
        uop_ready_in   = 1'b0;
        #1;
        chk("flush_count", count_out, 0);
        chk("flush_valid", uop_valid_out, 0);
        step();
        chk("flush_dropped", count_out, 0);
        push_one(32'h002081B3, 32'h40C);
        chk("flush_after_pc", pc_out, 32'h40C);
        chk("flush_after_count", count_out, 1);

        // Reset in the middle of traffic while halted.
        push_one(32'hDEADBEEF, 32'h410);
        chk("mid_pre_halt", halted_out, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", uop_valid_out, 0);
        chk("mid_rst_ready", instr_ready_out, 0);
        chk("mid_rst_uop", uop_out, 0);
        chk("mid_rst_pc", pc_out, 0);
        chk("mid_rst_eoi", eoi_out, 0);
        step();
        chk("mid_rst_count", count_out, 0);
        chk("mid_rst_imm", imm_out, 0);
        chk("mid_rst_halted", halted_out, 0);
        rst = 1'b0;
        #1;
        chk("mid_after_count", count_out, 0);
        chk("mid_after_ready", instr_ready_out, 1);
        chk("mid_after_valid", uop_valid_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
